hb_cipher_r: RTL and testbench

- One round of the HB 64-bit block cipher: a substitution-permutation round plus the matching key-schedule step.
- Instantiated by the iterative HB cipher top, which feeds back the registered round output and round key and supplies an 8-bit round counter.
- Round datapath is combinational. Both results are captured in output registers, giving one clock of latency.

---
 rtl/hb_cipher_r.sv | 126 ++++++++++++
 tb/tb_hb_cipher_r.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hb_cipher_r.sv
// ---------------------------------------------------------------------------
// hb_cipher_r : one round of the HB 64-bit block cipher
//
// Computes one substitution-permutation round together with the matching
// key-schedule step. Both results are registered, giving one clock of
// latency from din/kin/cnt to te/r_key. An iterative top feeds te and r_key
// back as din and kin and steps cnt once per round.
//
// All vectors are [0:63] with bit 0 as the MSB.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset (clears te and r_key)
//   te    : registered round output state
//   r_key : registered next round key
//   din   : round input state
//   kin   : current round key
//   cnt   : round counter, only the five LSBs cnt[3:7] are used
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// hb_cipher_r_sbox : 4-bit HB S-box, nibble MSB is the lower index
//
// Ports
//   x : nibble in
//   y : substituted nibble out
// ---------------------------------------------------------------------------
module hb_cipher_r_sbox (
   input  logic [0:3] x,
   output logic [0:3] y
);

   // Plain lookup table; the default keeps the block latch-free even though
   // every input value is listed.
   always_comb begin
      y = 4'h0;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
   end

endmodule

module hb_cipher_r (
   input  logic        clk,
   input  logic        rst,
   output logic [0:63] te,
   output logic [0:63] r_key,
   input  logic [0:63] din,
   input  logic [0:63] kin,
   input  logic [0:7]  cnt
);

   localparam int N = 63;

   logic [0:N] k_rot;
   logic [0:3] k_sub;
   logic [0:N] k_next;
   logic [0:N] s;
   logic [0:N] p;
   logic [0:N] t_next;
   logic       unused_cnt_hi;

   // The three upper counter bits are deliberately ignored so the round
   // counter may wrap freely in the caller.
   assign unused_cnt_hi = ^cnt[0:2];

   // Key schedule: rotate left by 13, substitute the top nibble, then inject
   // the 5-bit round counter into the bottom five bits.
   assign k_rot = {kin[13:N], kin[0:12]};

   hb_cipher_r_sbox u_key_sbox (
      .x(k_rot[0:3]),
      .y(k_sub)
   );

   assign k_next = {k_sub, k_rot[4:58], k_rot[59:N] ^ cnt[3:7]};

   // Substitution layer: sixteen independent S-boxes, nibble j covers
   // bits [4j:4j+3].
   for (genvar j = 0; j < 16; j++) begin : g_sbox
      hb_cipher_r_sbox u_sbox (
         .x(din[4*j +: 4]),
         .y(s[4*j +: 4])
      );
   end

   // Permutation layer, expressed in LSB-based indices: the bit at LSB index
   // l moves to 16*l mod 63, except bit 63 which stays put. The mapping is a
   // bijection, so every bit of p is driven exactly once.
   for (genvar l = 0; l < 64; l++) begin : g_perm
      localparam int DST = (l == 63) ? 63 : ((16 * l) % 63);
      assign p[N - DST] = s[N - l];
   end

   // The freshly scheduled key is also the whitening key for this round.
   assign t_next = p ^ k_next;

   // Output registers; reset wins over any input activity on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         te    <= 64'h0;
         r_key <= 64'h0;
      end else begin
         te    <= t_next;
         r_key <= k_next;
      end
   end

endmodule

// File: tb/tb_hb_cipher_r.sv
// ---------------------------------------------------------------------------
// tb_hb_cipher_r : self-checking bench for hb_cipher_r
//
// Directed steps drive one round per clock; each step pushes its expected
// te/r_key into a scoreboard queue and the following check pops and compares
// one clock later. Expected values come from spec constants or from an
// independent LSB-indexed software model of the round.
// ---------------------------------------------------------------------------
module tb_hb_cipher_r;

   typedef struct {
      string       tag;
      logic [63:0] te;
      logic [63:0] key;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [0:63] te;
   logic [0:63] r_key;
   logic [0:63] din;
   logic [0:63] kin;
   logic [0:7]  cnt;

   exp_t        sb[$];
   int          errors;
   int          checks;

   hb_cipher_r dut (
      .clk  (clk),
      .rst  (rst),
      .te   (te),
      .r_key(r_key),
      .din  (din),
      .kin  (kin),
      .cnt  (cnt)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference S-box written as a table.
   function automatic logic [3:0] modelSbox(input logic [3:0] x);
      logic [3:0] lut [16];
      lut = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
      return lut[x];
   endfunction

   // Reference key schedule in conventional [63:0] numbering.
   function automatic logic [63:0] modelKey(input logic [63:0] k, input logic [7:0] c);
      logic [63:0] r;
      r         = {k[50:0], k[63:51]};
      r[63:60]  = modelSbox(r[63:60]);
      r[4:0]    = r[4:0] ^ c[4:0];
      return r;
   endfunction

   // Reference round in conventional [63:0] numbering.
   function automatic logic [63:0] modelRound(input logic [63:0] d, input logic [63:0] kn);
      logic [63:0] s;
      logic [63:0] p;
      for (int n = 0; n < 16; n++) begin
         s[4*n +: 4] = modelSbox(d[4*n +: 4]);
      end
      p = '0;
      for (int l = 0; l < 64; l++) begin
         if (l == 63) p[63] = s[63];
         else         p[(16 * l) % 63] = s[l];
      end
      return p ^ kn;
   endfunction

   // Drive one round's inputs away from the active edge and record the
   // result the DUT should present after the next rising edge.
   task automatic applyStimulus(input string tag, input logic r, input logic [63:0] d,
                                input logic [63:0] k, input logic [7:0] c,
                                input logic [63:0] expTe, input logic [63:0] expKey);
      exp_t e;
      @(negedge clk);
      rst = r;
      din = d;
      kin = k;
      cnt = c;
      e.tag = tag;
      e.te  = expTe;
      e.key = expKey;
      sb.push_back(e);
   endtask

   // Let the edge happen, then pop the oldest expectation and compare.
   task automatic checkOutput();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard: observed=empty required=entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (te === e.te) else begin
            errors++;
            $error("[TB] FAIL %s te: observed=%h required=%h", e.tag, te, e.te);
         end
         checks++;
         assert (r_key === e.key) else begin
            errors++;
            $error("[TB] FAIL %s r_key: observed=%h required=%h", e.tag, r_key, e.key);
         end
      end
   endtask

   // Directed sequence followed by a 32-round loopback run.
   initial begin
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] k;
      logic [63:0] kn;
      logic [63:0] t;
      logic [7:0]  c;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      din = 64'h0;
      kin = 64'h0;
      cnt = 8'h0;

      $display("[TB] starting hb_cipher_r bench");

      applyStimulus("reset0", 1'b1, 64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 8'hA7, 64'h0, 64'h0);
      checkOutput();
      applyStimulus("reset1", 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFEDCBA9876543210, 8'h1F, 64'h0, 64'h0);
      checkOutput();

      applyStimulus("zero", 1'b0, 64'h0, 64'h0, 8'h00, 64'h3FFFFFFF00000000, 64'hC000000000000000);
      checkOutput();
      applyStimulus("cnt05", 1'b0, 64'h0, 64'h0, 8'h05, 64'h3FFFFFFF00000005, 64'hC000000000000005);
      checkOutput();
      applyStimulus("cnt25", 1'b0, 64'h0, 64'h0, 8'h25, 64'h3FFFFFFF00000005, 64'hC000000000000005);
      checkOutput();
      applyStimulus("cntFF", 1'b0, 64'h0, 64'h0, 8'hFF, 64'h3FFFFFFF0000001F, 64'hC00000000000001F);
      checkOutput();
      applyStimulus("allones", 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'h00, 64'hC0000000FFFF0000, 64'hC000000000000000);
      checkOutput();
      applyStimulus("keyrot", 1'b0, 64'h0, 64'h1, 8'h00, 64'h3FFFFFFF00002000, 64'hC000000000002000);
      checkOutput();

      applyStimulus("midreset", 1'b1, 64'h0, 64'h1, 8'h00, 64'h0, 64'h0);
      checkOutput();
      applyStimulus("postreset", 1'b0, 64'h0, 64'h1, 8'h00, 64'h3FFFFFFF00002000, 64'hC000000000002000);
      checkOutput();

      a = 64'h0123456789ABCDEF;
      k = 64'h0011223344556677;
      d = a ^ k;
      for (int i = 0; i < 32; i++) begin
         c  = {3'($urandom_range(0, 7)), 5'(i)};
         kn = modelKey(k, c);
         t  = modelRound(d, kn);
         applyStimulus($sformatf("iter%0d", i), 1'b0, d, k, c, t, kn);
         checkOutput();
         d = t;
         k = kn;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
